// File: rtl/exunit_br_q_pkg.sv
// Shared constants for the branch unit: RV32 widths and branch compare encodings.
package exunit_br_q_pkg;

  localparam int RV32_DATA_W = 32;
  localparam int RV32_PC_W   = 32;
  localparam int RV32_TAG_W  = 6;
  localparam int ALU_OP_SEL  = 3;

  // funct3-style encodings; 3'b010 and 3'b011 are unused and resolve not-taken
  typedef enum logic [ALU_OP_SEL-1:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_op_e;

endpackage

// File: rtl/exunit_br_q_br_resolve.sv
// Combinational branch resolver: compare, target generation and prediction check.
module br_resolve
  import exunit_br_q_pkg::*;
#(
  parameter int DATA_W = RV32_DATA_W,
  parameter int PC_W   = RV32_PC_W
) (
  input  logic                  is_jal_i,
  input  logic                  is_jalr_i,
  input  logic [ALU_OP_SEL-1:0] alu_op_sel_i,
  input  logic [DATA_W-1:0]     rs1_i,
  input  logic [DATA_W-1:0]     rs2_i,
  input  logic [DATA_W-1:0]     imm_i,
  input  logic [PC_W-1:0]       pc_i,
  input  logic [PC_W-1:0]       pred_jmpaddr_i,
  output logic [PC_W-1:0]       pc_plus4_o,
  output logic [PC_W-1:0]       jmpaddr_o,
  output logic                  jmpcond_o,
  output logic                  prsucc_o
);

  logic            cmp_taken;
  logic [PC_W-1:0] jalr_sum;
  logic [PC_W-1:0] target;

  always_comb begin
    cmp_taken = 1'b0;
    case (alu_op_sel_i)
      BR_BEQ:  cmp_taken = (rs1_i == rs2_i);
      BR_BNE:  cmp_taken = (rs1_i != rs2_i);
      BR_BLT:  cmp_taken = ($signed(rs1_i) <  $signed(rs2_i));
      BR_BGE:  cmp_taken = ($signed(rs1_i) >= $signed(rs2_i));
      BR_BLTU: cmp_taken = (rs1_i <  rs2_i);
      BR_BGEU: cmp_taken = (rs1_i >= rs2_i);
      default: cmp_taken = 1'b0;
    endcase
  end

  assign jalr_sum   = rs1_i[PC_W-1:0] + imm_i[PC_W-1:0];
  assign target     = is_jalr_i ? {jalr_sum[PC_W-1:1], 1'b0} : (pc_i + imm_i[PC_W-1:0]);
  assign pc_plus4_o = pc_i + PC_W'(4);
  assign jmpcond_o  = is_jal_i | is_jalr_i | cmp_taken;
  assign jmpaddr_o  = jmpcond_o ? target : pc_plus4_o;
  assign prsucc_o   = (jmpaddr_o == pred_jmpaddr_i);

endmodule

// File: rtl/exunit_br_q.sv
// Branch execution unit: one-cycle resolve feeding a DEPTH-entry flushable result queue.
module exunit_br_q
  import exunit_br_q_pkg::*;
#(
  parameter int DATA_W = RV32_DATA_W,
  parameter int PC_W   = RV32_PC_W,
  parameter int TAG_W  = RV32_TAG_W,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  o_accessable,
  input  logic                  i_is_vld,
  input  logic                  i_is_jal,
  input  logic                  i_is_jalr,
  input  logic [ALU_OP_SEL-1:0] i_alu_op_sel,
  input  logic [DATA_W-1:0]     i_rs1,
  input  logic [DATA_W-1:0]     i_rs2,
  input  logic [DATA_W-1:0]     i_imm,
  input  logic [PC_W-1:0]       i_pc,
  input  logic [PC_W-1:0]       i_pred_jmpaddr,
  input  logic [TAG_W-1:0]      i_tag,
  input  logic                  i_flush,
  output logic                  o_exfin_vld,
  input  logic                  i_exfin_rdy,
  output logic [TAG_W-1:0]      o_exfin_tag,
  output logic                  o_exfin_jal_jalr,
  output logic [DATA_W-1:0]     o_exfin_jal_jalr_res,
  output logic [PC_W-1:0]       o_exfin_jmpaddr,
  output logic                  o_exfin_jmpcond,
  output logic                  o_exfin_prsucc,
  output logic                  o_exfin_prmiss
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic              jal_jalr;
    logic [DATA_W-1:0] res;
    logic [PC_W-1:0]   jmpaddr;
    logic              jmpcond;
    logic              prsucc;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            push, pop;
  logic [PC_W-1:0] rs_pc_plus4, rs_jmpaddr;
  logic            rs_jmpcond, rs_prsucc;
  entry_t          new_entry, head;

  br_resolve #(.DATA_W(DATA_W), .PC_W(PC_W)) u_resolve (
    .is_jal_i       (i_is_jal),
    .is_jalr_i      (i_is_jalr),
    .alu_op_sel_i   (i_alu_op_sel),
    .rs1_i          (i_rs1),
    .rs2_i          (i_rs2),
    .imm_i          (i_imm),
    .pc_i           (i_pc),
    .pred_jmpaddr_i (i_pred_jmpaddr),
    .pc_plus4_o     (rs_pc_plus4),
    .jmpaddr_o      (rs_jmpaddr),
    .jmpcond_o      (rs_jmpcond),
    .prsucc_o       (rs_prsucc)
  );

  // Status comes only from registered count, so no rdy -> accessable path exists
  assign o_accessable = (count_q < DEPTH_C);
  assign o_exfin_vld  = (count_q != '0);
  assign push         = i_is_vld && o_accessable && !i_flush;
  assign pop          = o_exfin_vld && i_exfin_rdy;

  assign new_entry = '{tag:      i_tag,
                       jal_jalr: i_is_jal | i_is_jalr,
                       res:      DATA_W'(rs_pc_plus4),
                       jmpaddr:  rs_jmpaddr,
                       jmpcond:  rs_jmpcond,
                       prsucc:   rs_prsucc};

  assign head = o_exfin_vld ? mem_q[rd_ptr_q] : '0;

  assign o_exfin_tag          = head.tag;
  assign o_exfin_jal_jalr     = head.jal_jalr;
  assign o_exfin_jal_jalr_res = head.res;
  assign o_exfin_jmpaddr      = head.jmpaddr;
  assign o_exfin_jmpcond      = head.jmpcond;
  assign o_exfin_prsucc       = head.prsucc;
  assign o_exfin_prmiss       = o_exfin_vld & ~head.prsucc;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Writes never target the head slot while it is valid, so the head is stable under backpressure
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(i_is_vld && !i_flush && !o_accessable));
  end

endmodule

// File: tb/tb_exunit_br_q.sv
// Scoreboard bench for exunit_br_q: directed branch cases, full/flush/reset, then random traffic.
module tb_exunit_br_q;
  import exunit_br_q_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        o_accessable;
  logic        i_is_vld, i_is_jal, i_is_jalr;
  logic [2:0]  i_alu_op_sel;
  logic [31:0] i_rs1, i_rs2, i_imm, i_pc, i_pred_jmpaddr;
  logic [5:0]  i_tag;
  logic        i_flush;
  logic        o_exfin_vld, i_exfin_rdy;
  logic [5:0]  o_exfin_tag;
  logic        o_exfin_jal_jalr;
  logic [31:0] o_exfin_jal_jalr_res, o_exfin_jmpaddr;
  logic        o_exfin_jmpcond, o_exfin_prsucc, o_exfin_prmiss;

  always #5 clk = ~clk;

  exunit_br_q dut (
    .clk(clk), .rst(rst), .o_accessable(o_accessable),
    .i_is_vld(i_is_vld), .i_is_jal(i_is_jal), .i_is_jalr(i_is_jalr),
    .i_alu_op_sel(i_alu_op_sel), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm),
    .i_pc(i_pc), .i_pred_jmpaddr(i_pred_jmpaddr), .i_tag(i_tag), .i_flush(i_flush),
    .o_exfin_vld(o_exfin_vld), .i_exfin_rdy(i_exfin_rdy), .o_exfin_tag(o_exfin_tag),
    .o_exfin_jal_jalr(o_exfin_jal_jalr), .o_exfin_jal_jalr_res(o_exfin_jal_jalr_res),
    .o_exfin_jmpaddr(o_exfin_jmpaddr), .o_exfin_jmpcond(o_exfin_jmpcond),
    .o_exfin_prsucc(o_exfin_prsucc), .o_exfin_prmiss(o_exfin_prmiss)
  );

  typedef struct packed {
    logic [5:0]  tag;
    logic        jj;
    logic [31:0] res;
    logic [31:0] addr;
    logic        cond;
    logic        succ;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic exp_t ref_br(input logic jal, input logic jalr, input logic [2:0] op,
                                  input logic [31:0] rs1, input logic [31:0] rs2,
                                  input logic [31:0] imm, input logic [31:0] pc,
                                  input logic [31:0] pred, input logic [5:0] tag);
    logic        taken;
    logic [31:0] tgt, nxt;
    case (op)
      BR_BEQ:  taken = (rs1 == rs2);
      BR_BNE:  taken = (rs1 != rs2);
      BR_BLT:  taken = ($signed(rs1) <  $signed(rs2));
      BR_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      BR_BLTU: taken = (rs1 <  rs2);
      BR_BGEU: taken = (rs1 >= rs2);
      default: taken = 1'b0;
    endcase
    if (jal || jalr) taken = 1'b1;
    tgt = jalr ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
    nxt = taken ? tgt : (pc + 32'd4);
    return '{tag: tag, jj: jal | jalr, res: pc + 32'd4, addr: nxt, cond: taken, succ: (nxt == pred)};
  endfunction

  task automatic set_br(input logic jal, input logic jalr, input logic [2:0] op,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                        input logic [31:0] pc, input logic [31:0] pred, input logic [5:0] tag);
    i_is_vld = 1'b1; i_is_jal = jal; i_is_jalr = jalr; i_alu_op_sel = op;
    i_rs1 = rs1; i_rs2 = rs2; i_imm = imm; i_pc = pc; i_pred_jmpaddr = pred; i_tag = tag;
  endtask

  // Called at a falling edge with this cycle's inputs already driven.
  task automatic tick(input exp_t e);
    chk("vld", o_exfin_vld, sb.size() != 0);
    chk("acc", o_accessable, sb.size() < 4);
    if (o_exfin_vld && sb.size() != 0) begin
      chk("tag", o_exfin_tag, sb[0].tag);
      chk("jmpaddr", o_exfin_jmpaddr, sb[0].addr);
      chk("res", o_exfin_jal_jalr_res, sb[0].res);
      chk("flags", {o_exfin_jal_jalr, o_exfin_jmpcond, o_exfin_prsucc, o_exfin_prmiss},
          {sb[0].jj, sb[0].cond, sb[0].succ, !sb[0].succ});
      if (i_exfin_rdy) void'(sb.pop_front());
    end else if (!o_exfin_vld) begin
      chk("idle_data", {o_exfin_jal_jalr_res, o_exfin_jmpaddr}, 64'd0);
      chk("idle_flags", {o_exfin_tag, o_exfin_jal_jalr, o_exfin_jmpcond, o_exfin_prsucc, o_exfin_prmiss}, 64'd0);
    end
    if (rst || i_flush) sb.delete();
    else if (i_is_vld && o_accessable) sb.push_back(e);
    @(negedge clk);
    i_is_vld = 1'b0;
    i_flush  = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    rst = 1'b1; i_flush = 1'b0; i_exfin_rdy = 1'b1;
    i_is_vld = 1'b0; i_is_jal = 1'b0; i_is_jalr = 1'b0; i_alu_op_sel = '0;
    i_rs1 = '0; i_rs2 = '0; i_imm = '0; i_pc = '0; i_pred_jmpaddr = '0; i_tag = '0;
    repeat (2) @(negedge clk);
    chk("rst_vld", o_exfin_vld, 0);
    chk("rst_acc", o_accessable, 1);
    chk("rst_data", {o_exfin_jal_jalr_res, o_exfin_jmpaddr}, 64'd0);
    rst = 1'b0;

    // Directed resolves, back-to-back with rdy=1
    set_br(0, 0, BR_BEQ, 32'd5, 32'd5, 32'h20, 32'h100, 32'h120, 6'd1);
    tick('{tag: 6'd1, jj: 0, res: 32'h104, addr: 32'h120, cond: 1, succ: 1});
    chk("beq_lat_vld", o_exfin_vld, 1);
    chk("beq_jmpaddr", o_exfin_jmpaddr, 32'h120);
    set_br(0, 0, BR_BLT, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h200, 32'h204, 6'd2);
    tick('{tag: 6'd2, jj: 0, res: 32'h204, addr: 32'h240, cond: 1, succ: 0});
    set_br(0, 0, BR_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h200, 32'h204, 6'd3);
    tick('{tag: 6'd3, jj: 0, res: 32'h204, addr: 32'h204, cond: 0, succ: 1});
    set_br(0, 1, BR_BEQ, 32'h1001, 32'd0, 32'h4, 32'h300, 32'h1004, 6'd7);
    tick('{tag: 6'd7, jj: 1, res: 32'h304, addr: 32'h1004, cond: 1, succ: 1});
    set_br(1, 0, BR_BEQ, 32'd0, 32'd0, 32'hFFFF_FFF8, 32'h400, 32'h0, 6'd8);
    tick('{tag: 6'd8, jj: 1, res: 32'h404, addr: 32'h3F8, cond: 1, succ: 0});
    repeat (2) tick('0);

    // Fill with rdy=0, hold, then drain in order
    i_exfin_rdy = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      e = ref_br(0, 0, BR_BNE, 32'd9, 32'd9, 32'h8, 32'h500 + 32'(k * 16), 32'h504 + 32'(k * 16), 6'(k));
      set_br(0, 0, BR_BNE, 32'd9, 32'd9, 32'h8, 32'h500 + 32'(k * 16), 32'h504 + 32'(k * 16), 6'(k));
      tick(e);
      if (k == 3) chk("acc_3_entries", o_accessable, 1);
    end
    chk("acc_full", o_accessable, 0);
    repeat (3) tick('0);
    chk("hold_head_tag", o_exfin_tag, 6'd1);
    i_exfin_rdy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("drain_tag", o_exfin_tag, 6'(k));
      tick('0);
      if (k == 1) chk("acc_after_pop", o_accessable, 1);
    end
    chk("drain_vld", o_exfin_vld, 0);

    // Three entries, then flush together with an issue
    i_exfin_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      e = ref_br(0, 0, BR_BGE, 32'd3, 32'd2, 32'h10, 32'h600 + 32'(k * 4), 32'h610, 6'(17 + k));
      set_br(0, 0, BR_BGE, 32'd3, 32'd2, 32'h10, 32'h600 + 32'(k * 4), 32'h610, 6'(17 + k));
      tick(e);
    end
    set_br(1, 0, BR_BEQ, 32'd0, 32'd0, 32'h40, 32'h700, 32'h740, 6'h3F);
    i_flush = 1'b1;
    tick('{tag: 6'h3F, jj: 1, res: 32'h704, addr: 32'h740, cond: 1, succ: 1});
    chk("flush_vld", o_exfin_vld, 0);
    chk("flush_acc", o_accessable, 1);
    i_exfin_rdy = 1'b1;
    repeat (3) tick('0);

    // Reset while full, then a fresh issue
    i_exfin_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      e = ref_br(0, 0, BR_BGEU, 32'd1, 32'd2, 32'h8, 32'h800 + 32'(k * 4), 32'h0, 6'(32 + k));
      set_br(0, 0, BR_BGEU, 32'd1, 32'd2, 32'h8, 32'h800 + 32'(k * 4), 32'h0, 6'(32 + k));
      tick(e);
    end
    rst = 1'b1;
    tick('0);
    rst = 1'b0;
    chk("rstfull_vld", o_exfin_vld, 0);
    chk("rstfull_acc", o_accessable, 1);
    chk("rstfull_data", {o_exfin_jal_jalr_res, o_exfin_jmpaddr}, 64'd0);
    i_exfin_rdy = 1'b1;
    set_br(0, 0, BR_BNE, 32'd1, 32'd2, 32'h100, 32'h900, 32'hA00, 6'd42);
    tick('{tag: 6'd42, jj: 0, res: 32'h904, addr: 32'hA00, cond: 1, succ: 1});
    chk("rstfull_fresh_vld", o_exfin_vld, 1);
    chk("rstfull_fresh_tag", o_exfin_tag, 6'd42);
    tick('0);

    // Random traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      logic        jal, jalr;
      logic [2:0]  op;
      logic [31:0] rs1, rs2, imm, pc, pred;
      i_exfin_rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0) i_flush = 1'b1;
      if (o_accessable && $urandom_range(0, 3) != 0) begin
        jal  = ($urandom_range(0, 7) == 0);
        jalr = !jal && ($urandom_range(0, 7) == 0);
        op   = 3'($urandom_range(0, 7));
        rs1  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 4));
        rs2  = ($urandom_range(0, 3) == 0) ? rs1 : (($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 4)));
        imm  = $urandom;
        pc   = $urandom;
        e    = ref_br(jal, jalr, op, rs1, rs2, imm, pc, 32'h0, 6'(c));
        pred = ($urandom_range(0, 1) != 0) ? e.addr : (pc + 32'd4);
        e    = ref_br(jal, jalr, op, rs1, rs2, imm, pc, pred, 6'(c));
        set_br(jal, jalr, op, rs1, rs2, imm, pc, pred, 6'(c));
        tick(e);
      end else begin
        tick('0);
      end
    end

    i_exfin_rdy = 1'b1;
    for (int k = 0; k < 40 && (sb.size() != 0 || o_exfin_vld); k++) tick('0);
    chk("final_drained", (sb.size() == 0) && !o_exfin_vld, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
